addsub_arb: RTL and testbench
=============================

ADDSUB_ARB -- requirements
Module: addsub_arb

Interface
REQ-001 SHALL have ports, clock and reset first: clk  in  1  single clock, all state on rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have per-requester ports, i in {0,1}: req_i in 1 request; a_i in 16 operand A; b_i in 16 operand B; sub_i in 1 subtract; mem_i in 1 address op, no saturation; gnt_i out 1 accept strobe; rsp_vld_i out 1 response strobe.
REQ-003 SHALL have shared response ports: rsp_data out 16 result; rsp_ovfl out 1 overflow flag; stall in 1 freeze pipeline.
REQ-004 SHALL have adder-side ports: add_a out 16, add_b out 16, add_sub out 1, add_mem out 1 to the shared 16-bit saturating add/sub unit; add_result in 16, add_ovfl in 1 from it (combinational).
REQ-005 SHALL expose, only under ADDSUB_ARB_OVCNT_EN: ovcnt out 8 overflow count; ovcnt_clr in 1 synchronous clear.

Function
REQ-006 SHALL be a 3-stage pipeline: ARB (accept), EXE (drive adder, capture), RSP (present response); accept-to-rsp_vld latency exactly 2 cycles; throughput one op per cycle.
REQ-007 SHALL compute gnt_i combinationally in ARB; a request is accepted when req_i & gnt_i on a rising edge; at most one gnt_i high per cycle; gnt_i low whenever stall=1.
REQ-008 SHALL arbitrate round-robin: pointer lrg = last granted requester; both requesting -> grant the one not equal to lrg; one requesting -> grant it; lrg updates only on accept.
REQ-009 SHALL, on accept, latch {a,b,sub,mem,id} into the EXE register with exe_vld=1; no accept and no stall -> exe_vld=0.
REQ-010 SHALL drive add_a/add_b/add_sub/add_mem from the EXE register; when exe_vld=0 they SHALL be 0.
REQ-011 SHALL capture add_result, add_ovfl and id into the RSP register when exe_vld=1 and stall=0; rsp_vld_i = rsp_reg_vld & (rsp_id==i), one-cycle pulse per op.
REQ-012 SHALL pass rsp_ovfl = add_ovfl unchanged, including for mem_op=1, where the result is unsaturated.
REQ-013 SHALL, when stall=1, hold EXE and RSP registers and lrg; rsp_vld_i SHALL stay asserted for an op held in RSP, so requesters see it for every stalled cycle plus the release cycle.
REQ-014 SHALL drop no op and duplicate no op across any stall pattern; per-requester response order equals accept order.
REQ-015 SHALL leave requests not granted to the requester to hold; the arbiter SHALL not queue them.

Reset
REQ-016 SHALL, on rst_n=0 asynchronously: gnt_i=0, rsp_vld_i=0, rsp_data=0, rsp_ovfl=0, add_a/add_b=0, add_sub/add_mem=0, exe_vld=0, lrg=1 so requester 0 wins first, ovcnt=0.
REQ-017 SHALL discard in-flight ops on reset mid-operation; no response pulses after release until new accepts; first accept is possible on the first rising edge with rst_n=1.

Configuration
REQ-018 SHALL compile in an overflow counter when ADDSUB_ARB_OVCNT_EN is defined: ovcnt increments on each RSP capture with add_ovfl=1 and add_mem=0, saturates at 8'hFF, and clears on ovcnt_clr, where clear wins over increment.
REQ-019 SHALL, without ADDSUB_ARB_OVCNT_EN, omit ovcnt and ovcnt_clr ports and counter logic; all other behaviour is identical.

Verification
REQ-020 SHALL cover: req0 alone, A=0005 B=0008 sub=0 mem=0 -> gnt0 cycle 0, rsp_vld0 cycle 2, rsp_data=000D, rsp_ovfl=0.
REQ-021 SHALL cover: req0 and req1 held high for 4 cycles after reset -> grants 0,1,0,1; rsp_vld alternates 0,1,0,1 starting cycle 2.
REQ-022 SHALL cover: req1 A=7FFF B=8000 sub=1 mem=0 -> rsp_data=7FFF, rsp_ovfl=1; same operands with mem=1 -> rsp_data=FFFF, rsp_ovfl=1; ovcnt +1 only for the first (OVCNT_EN).
REQ-023 SHALL cover: stall=1 for 3 cycles with ops in EXE and RSP -> gnt low, rsp_vld held with stable data, no loss or duplication; order preserved after release.
REQ-024 SHALL cover: rst_n pulsed low with 2 ops in flight -> all outputs 0 immediately, no rsp_vld after release, next simultaneous request granted to requester 0.
REQ-025 SHALL cover (OVCNT_EN): 300 overflowing adds with A=7000 B=7000 -> ovcnt=FF; ovcnt_clr during an overflow capture -> ovcnt=00.

Source files
------------

// File: rtl/addsub_arb.sv
`default_nettype none
//==============================================================================
// Module   : addsub_arb
// Brief    : Two-requester round-robin front end (ARB/EXE/RSP pipeline) for a
//            shared 16-bit saturating add/sub unit. Define ADDSUB_ARB_OVCNT_EN
//            to add the ovcnt/ovcnt_clr overflow counter.
// Revision : 1.0  initial release
//==============================================================================
module addsub_arb (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                req_0,
    input  logic [15:0]         a_0,
    input  logic [15:0]         b_0,
    input  logic                sub_0,
    input  logic                mem_0,
    output logic                gnt_0,
    output logic                rsp_vld_0,

    input  logic                req_1,
    input  logic [15:0]         a_1,
    input  logic [15:0]         b_1,
    input  logic                sub_1,
    input  logic                mem_1,
    output logic                gnt_1,
    output logic                rsp_vld_1,

    output logic [15:0]         rsp_data,
    output logic                rsp_ovfl,
    input  logic                stall,

    output logic [15:0]         add_a,
    output logic [15:0]         add_b,
    output logic                add_sub,
    output logic                add_mem,
    input  logic [15:0]         add_result,
    input  logic                add_ovfl
`ifdef ADDSUB_ARB_OVCNT_EN
    ,
    output logic [7:0]          ovcnt,
    input  logic                ovcnt_clr
`endif
);

    localparam int unsigned C_W = 16;

    logic             r_lrg;
    logic             w_gnt_0;
    logic             w_gnt_1;
    logic             w_accept;
    logic             w_acc_id;
    logic [C_W-1:0]   w_sel_a;
    logic [C_W-1:0]   w_sel_b;
    logic             w_sel_sub;
    logic             w_sel_mem;

    logic             r_exe_vld;
    logic [C_W-1:0]   r_exe_a;
    logic [C_W-1:0]   r_exe_b;
    logic             r_exe_sub;
    logic             r_exe_mem;
    logic             r_exe_id;

    logic             r_rsp_vld;
    logic [C_W-1:0]   r_rsp_data;
    logic             r_rsp_ovfl;
    logic             r_rsp_id;

    logic             w_capture;

    // Grant is gated by rst_n so it drops the instant reset asserts.
    always_comb begin
        w_gnt_0 = 1'b0;
        w_gnt_1 = 1'b0;
        if (rst_n && !stall) begin
            if (req_0 && req_1) begin
                w_gnt_0 = r_lrg;
                w_gnt_1 = ~r_lrg;
            end else begin
                w_gnt_0 = req_0;
                w_gnt_1 = req_1;
            end
        end
    end

    assign gnt_0     = w_gnt_0;
    assign gnt_1     = w_gnt_1;
    assign w_accept  = w_gnt_0 | w_gnt_1;
    assign w_acc_id  = w_gnt_1;

    assign w_sel_a   = w_acc_id ? a_1   : a_0;
    assign w_sel_b   = w_acc_id ? b_1   : b_0;
    assign w_sel_sub = w_acc_id ? sub_1 : sub_0;
    assign w_sel_mem = w_acc_id ? mem_1 : mem_0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lrg     <= 1'b1;
            r_exe_vld <= 1'b0;
            r_exe_a   <= '0;
            r_exe_b   <= '0;
            r_exe_sub <= 1'b0;
            r_exe_mem <= 1'b0;
            r_exe_id  <= 1'b0;
        end else if (!stall) begin
            r_exe_vld <= w_accept;
            if (w_accept) begin
                r_exe_a   <= w_sel_a;
                r_exe_b   <= w_sel_b;
                r_exe_sub <= w_sel_sub;
                r_exe_mem <= w_sel_mem;
                r_exe_id  <= w_acc_id;
                r_lrg     <= w_acc_id;
            end
        end
    end

    assign add_a   = r_exe_vld ? r_exe_a : '0;
    assign add_b   = r_exe_vld ? r_exe_b : '0;
    assign add_sub = r_exe_vld & r_exe_sub;
    assign add_mem = r_exe_vld & r_exe_mem;

    assign w_capture = r_exe_vld & ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_vld  <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_ovfl <= 1'b0;
            r_rsp_id   <= 1'b0;
        end else if (!stall) begin
            r_rsp_vld <= r_exe_vld;
            if (r_exe_vld) begin
                r_rsp_data <= add_result;
                r_rsp_ovfl <= add_ovfl;
                r_rsp_id   <= r_exe_id;
            end
        end
    end

    // A response held in RSP keeps its strobe up for every stalled cycle.
    assign rsp_vld_0 = r_rsp_vld & ~r_rsp_id;
    assign rsp_vld_1 = r_rsp_vld &  r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_ovfl  = r_rsp_ovfl;

`ifdef ADDSUB_ARB_OVCNT_EN
    logic [7:0] r_ovcnt;

    // Address ops wrap by design, so their overflow is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovcnt <= 8'h00;
        end else if (ovcnt_clr) begin
            r_ovcnt <= 8'h00;
        end else if (w_capture && add_ovfl && !r_exe_mem && (r_ovcnt != 8'hFF)) begin
            r_ovcnt <= r_ovcnt + 8'd1;
        end
    end

    assign ovcnt = r_ovcnt;
`else
    // No overflow counter in this build; w_capture only feeds the counter.
    logic w_unused_capture;
    assign w_unused_capture = w_capture;
`endif

endmodule
`default_nettype wire

// File: tb/tb_addsub_arb.sv
`default_nettype none
// Randomized + directed bench for addsub_arb against a queue-based reference
// model; also models the external saturating add/sub unit.
module tb_addsub_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_0, req_1, sub_0, sub_1, mem_0, mem_1, stall;
    logic [15:0] a_0, b_0, a_1, b_1;
    logic        gnt_0, gnt_1, rsp_vld_0, rsp_vld_1;
    logic [15:0] rsp_data;
    logic        rsp_ovfl;
    logic [15:0] add_a, add_b, add_result;
    logic        add_sub, add_mem, add_ovfl;
`ifdef ADDSUB_ARB_OVCNT_EN
    logic [7:0]  ovcnt;
    logic        ovcnt_clr;
`endif

    addsub_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_0      (req_0),
        .a_0        (a_0),
        .b_0        (b_0),
        .sub_0      (sub_0),
        .mem_0      (mem_0),
        .gnt_0      (gnt_0),
        .rsp_vld_0  (rsp_vld_0),
        .req_1      (req_1),
        .a_1        (a_1),
        .b_1        (b_1),
        .sub_1      (sub_1),
        .mem_1      (mem_1),
        .gnt_1      (gnt_1),
        .rsp_vld_1  (rsp_vld_1),
        .rsp_data   (rsp_data),
        .rsp_ovfl   (rsp_ovfl),
        .stall      (stall),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_sub    (add_sub),
        .add_mem    (add_mem),
        .add_result (add_result),
        .add_ovfl   (add_ovfl)
`ifdef ADDSUB_ARB_OVCNT_EN
        ,
        .ovcnt      (ovcnt),
        .ovcnt_clr  (ovcnt_clr)
`endif
    );

    // Signed 16-bit add/sub; saturates unless mem is set. Returns {ovfl, result}.
    function automatic logic [16:0] alu(input logic [15:0] a, input logic [15:0] b,
                                        input logic s, input logic m);
        int          sa, sb, r;
        logic [15:0] res;
        logic        ov;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = s ? sa - sb : sa + sb;
        ov = (r > 32767) || (r < -32768);
        if (ov && !m) res = (r > 0) ? 16'h7FFF : 16'h8000;
        else          res = r[15:0];
        return {ov, res};
    endfunction

    always_comb {add_ovfl, add_result} = alu(add_a, add_b, add_sub, add_mem);

    typedef struct {
        int          id;
        logic [15:0] a, b, res;
        logic        sub, mem, ovf;
        int          age;   // non-stalled edges since accept
    } op_t;

    op_t         q[$];
    int          m_last;
    logic [15:0] m_data;
    logic        m_ovf;
    int          m_cnt;
    logic        m_g0, m_g1;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic set_idle();
        req_0 = 1'b0; req_1 = 1'b0; stall = 1'b0;
`ifdef ADDSUB_ARB_OVCNT_EN
        ovcnt_clr = 1'b0;
`endif
    endtask

    task automatic set_op(input int id, input logic r, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic m);
        if (id == 0) begin req_0 = r; a_0 = a; b_0 = b; sub_0 = s; mem_0 = m; end
        else         begin req_1 = r; a_1 = a; b_1 = b; sub_1 = s; mem_1 = m; end
    endtask

    // Entered at a falling edge with inputs set; checks, then advances one cycle.
    task automatic cycle();
        logic        eg0, eg1, ev0, ev1, es, em;
        logic [15:0] ea, eb;
        op_t         o;
        #1;
        eg0 = 1'b0; eg1 = 1'b0;
        if (!stall) begin
            if (req_0 && req_1) begin eg0 = (m_last == 1); eg1 = (m_last == 0); end
            else begin eg0 = req_0; eg1 = req_1; end
        end
        check("gnt_0", gnt_0, eg0);
        check("gnt_1", gnt_1, eg1);
        ea = '0; eb = '0; es = 1'b0; em = 1'b0; ev0 = 1'b0; ev1 = 1'b0;
        foreach (q[i]) begin
            if (q[i].age == 0) begin ea = q[i].a; eb = q[i].b; es = q[i].sub; em = q[i].mem; end
            if (q[i].age == 1) begin ev0 = (q[i].id == 0); ev1 = (q[i].id == 1); end
        end
        check("add_a", add_a, ea);
        check("add_b", add_b, eb);
        check("add_ctl", {add_sub, add_mem}, {es, em});
        check("rsp_vld_0", rsp_vld_0, ev0);
        check("rsp_vld_1", rsp_vld_1, ev1);
        check("rsp_data", rsp_data, m_data);
        check("rsp_ovfl", rsp_ovfl, m_ovf);
`ifdef ADDSUB_ARB_OVCNT_EN
        check("ovcnt", ovcnt, m_cnt);
`endif
        m_g0 = eg0; m_g1 = eg1;
        @(posedge clk);
        if (!stall) begin
            foreach (q[i]) q[i].age++;
            while (q.size() > 0 && q[0].age >= 2) void'(q.pop_front());
            foreach (q[i]) if (q[i].age == 1) begin
                m_data = q[i].res;
                m_ovf  = q[i].ovf;
                if (q[i].ovf && !q[i].mem && m_cnt < 255) m_cnt++;
            end
            if (eg0 || eg1) begin
                o.id  = eg1 ? 1 : 0;
                o.a   = eg1 ? a_1 : a_0;
                o.b   = eg1 ? b_1 : b_0;
                o.sub = eg1 ? sub_1 : sub_0;
                o.mem = eg1 ? mem_1 : mem_0;
                {o.ovf, o.res} = alu(o.a, o.b, o.sub, o.mem);
                o.age = 0;
                q.push_back(o);
                m_last = o.id;
            end
        end
`ifdef ADDSUB_ARB_OVCNT_EN
        if (ovcnt_clr) m_cnt = 0;
`endif
        @(negedge clk);
    endtask

    // Entered at a falling edge; asserts reset mid-cycle and checks outputs at once.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_gnt", {gnt_0, gnt_1}, 2'b00);
        check("rst_vld", {rsp_vld_0, rsp_vld_1}, 2'b00);
        check("rst_rsp", {rsp_data, rsp_ovfl}, 17'h0);
        check("rst_add", {add_a, add_b, add_sub, add_mem}, 34'h0);
`ifdef ADDSUB_ARB_OVCNT_EN
        check("rst_ovcnt", ovcnt, 8'h00);
`endif
        q.delete();
        m_last = 1; m_data = '0; m_ovf = 1'b0; m_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 3))
            0: pick = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
            1: pick = 16'($urandom_range(0, 15));
            default: pick = 16'($urandom);
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        a_0 = '0; b_0 = '0; a_1 = '0; b_1 = '0;
        sub_0 = 1'b0; mem_0 = 1'b0; sub_1 = 1'b0; mem_1 = 1'b0;
        set_idle();
        m_g0 = 1'b0; m_g1 = 1'b0;
        @(negedge clk);

        // single add from requester 0
        do_reset();
        set_op(0, 1'b1, 16'h0005, 16'h0008, 1'b0, 1'b0);
        #1 check("d_single_gnt0", gnt_0, 1'b1);
        cycle();
        set_idle();
        cycle();
        #1;
        check("d_single_vld0", rsp_vld_0, 1'b1);
        check("d_single_data", rsp_data, 16'h000D);
        check("d_single_ovfl", rsp_ovfl, 1'b0);
        repeat (2) cycle();

        // both requesting: alternating grants starting with requester 0
        do_reset();
        set_op(0, 1'b1, 16'h1234, 16'h0101, 1'b0, 1'b0);
        set_op(1, 1'b1, 16'h0300, 16'h0021, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1 check("d_rr_gnt1", gnt_1, k % 2);
            cycle();
        end
        set_idle();
        repeat (3) cycle();

        // saturating vs address subtract
        do_reset();
        set_op(1, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b0);
        cycle();
        set_op(1, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1);
        cycle();
        set_idle();
        #1 check("d_sat_rsp", {rsp_vld_1, rsp_data, rsp_ovfl}, {1'b1, 16'h7FFF, 1'b1});
        cycle();
        #1 check("d_mem_rsp", {rsp_vld_1, rsp_data, rsp_ovfl}, {1'b1, 16'hFFFF, 1'b1});
        cycle();
`ifdef ADDSUB_ARB_OVCNT_EN
        #1 check("d_sat_ovcnt", ovcnt, 8'h01);
`endif
        cycle();

        // stall for 3 cycles with ops in EXE and RSP
        do_reset();
        set_op(0, 1'b1, 16'h0010, 16'h0001, 1'b0, 1'b0);
        set_op(1, 1'b1, 16'h0020, 16'h0002, 1'b0, 1'b0);
        repeat (2) cycle();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("d_stall_gnt", {gnt_0, gnt_1}, 2'b00);
            check("d_stall_hold", {rsp_vld_0, rsp_data}, {1'b1, 16'h0011});
            cycle();
        end
        set_idle();
        repeat (4) cycle();

        // reset with two ops in flight
        do_reset();
        set_op(0, 1'b1, 16'h0100, 16'h0001, 1'b0, 1'b0);
        set_op(1, 1'b1, 16'h0200, 16'h0002, 1'b0, 1'b0);
        repeat (2) cycle();
        do_reset();
        set_idle();
        repeat (3) cycle();
        req_0 = 1'b1; req_1 = 1'b1;
        #1 check("d_rst_first_gnt", {gnt_0, gnt_1}, 2'b10);
        cycle();
        set_idle();
        repeat (3) cycle();

`ifdef ADDSUB_ARB_OVCNT_EN
        // counter saturation and clear-wins-over-increment
        do_reset();
        set_op(0, 1'b1, 16'h7000, 16'h7000, 1'b0, 1'b0);
        repeat (302) cycle();
        #1 check("d_ovcnt_sat", ovcnt, 8'hFF);
        ovcnt_clr = 1'b1;
        cycle();
        ovcnt_clr = 1'b0;
        #1 check("d_ovcnt_clr", ovcnt, 8'h00);
        set_idle();
        repeat (3) cycle();
`endif

        // randomized traffic; an ungranted request holds its operands
        do_reset();
        set_idle();
        m_g0 = 1'b0; m_g1 = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (!req_0 || m_g0)
                set_op(0, $urandom_range(0, 99) < 70, pick(), pick(),
                       1'($urandom_range(0, 1)), $urandom_range(0, 99) < 20);
            if (!req_1 || m_g1)
                set_op(1, $urandom_range(0, 99) < 70, pick(), pick(),
                       1'($urandom_range(0, 1)), $urandom_range(0, 99) < 20);
            stall = $urandom_range(0, 99) < 20;
`ifdef ADDSUB_ARB_OVCNT_EN
            ovcnt_clr = $urandom_range(0, 99) < 3;
`endif
            cycle();
        end
        set_idle();
        repeat (4) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
